// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard frame receiver: synchronises the raw PS/2 lines, deserialises
// 11-bit frames, queues good scan-code bytes in a small FIFO and tracks the
// make/break/extended state of the most recent key for the lookup stage.
module ps2_scan_receiver #(
    parameter int FIFO_AW        = 3,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_down
);

    localparam int                DEPTH   = 1 << FIFO_AW;
    localparam int                TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_ONE  = TO_W'(1);
    localparam logic [FIFO_AW:0]  PTR_ONE = (FIFO_AW + 1)'(1);
    localparam logic [7:0]        CODE_E0 = 8'hE0;
    localparam logic [7:0]        CODE_F0 = 8'hF0;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} dec_state_t;

    logic [2:0]        s_clk;
    logic [2:0]        s_data;
    logic              sync_unused;
    logic              fall;
    logic [3:0]        bit_cnt;
    logic [9:0]        shreg;
    logic [TO_W-1:0]   to_cnt;
    logic              frame_ok;
    logic              last_bit;
    logic              timeout;
    logic              vld_p1;
    logic              err_p1;
    logic [7:0]        byte_p1;
    logic [FIFO_AW:0]  wr_ptr;
    logic [FIFO_AW:0]  rd_ptr;
    logic [7:0]        mem [DEPTH];
    logic              full;
    logic              pop;
    logic              wr_en;
    dec_state_t        state;
    dec_state_t        state_nxt;
    logic [7:0]        code_nxt;
    logic              ext_nxt;
    logic              down_nxt;

    // The oldest data stage only exists so both synchronisers have equal depth.
    assign sync_unused = s_data[2];

    // s[0] is the newest sample; a falling edge is seen between s[2] and s[1].
    assign fall     = s_clk[2] & ~s_clk[1];
    // Shift register holds start at [0], d0..d7 at [8:1], parity at [9]; the
    // stop bit is still on s_data[1] when the 11th edge arrives.
    assign frame_ok = ~shreg[0] & s_data[1] & (^shreg[9:1]);
    assign last_bit = fall && (bit_cnt == 4'd10);
    assign timeout  = (bit_cnt != 4'd0) && !fall && (to_cnt == TO_LAST);

    // Three-flop synchronisers for the asynchronous PS/2 lines.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            s_clk  <= 3'b111;
            s_data <= 3'b111;
        end else begin
            s_clk  <= {s_clk[1:0], ps2_clk};
            s_data <= {s_data[1:0], ps2_data};
        end
    end

    // Bit counter, frame shift register and inter-edge timeout.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bit_cnt <= 4'd0;
            shreg   <= '0;
            to_cnt  <= '0;
        end else if (fall) begin
            to_cnt  <= '0;
            shreg   <= {s_data[1], shreg[9:1]};
            bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
        end else if (bit_cnt != 4'd0) begin
            if (timeout) begin
                bit_cnt <= 4'd0;
                to_cnt  <= '0;
            end else begin
                to_cnt  <= to_cnt + TO_ONE;
            end
        end else begin
            to_cnt <= '0;
        end
    end

    // Stage p1: frame verdict control (valid pulse and error pulse).
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
        end else begin
            vld_p1 <= last_bit & frame_ok;
            err_p1 <= (last_bit & ~frame_ok) | timeout;
        end
    end

    // Stage p1: received byte, qualified by vld_p1.
    always_ff @(posedge clk) begin
        if (last_bit) begin
            byte_p1 <= shreg[8:1];
        end
    end

    assign frame_err = err_p1;

    assign ready = (wr_ptr != rd_ptr);
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign pop   = ready & ~nextdata_n;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign wr_en = vld_p1 & (~full | pop);
    assign data  = mem[rd_ptr[FIFO_AW-1:0]];

    // FIFO pointers and sticky overflow flag.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (vld_p1 && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO storage; cleared on reset so the head byte reads 0 out of reset.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (wr_en) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= byte_p1;
        end
    end

    // Decoder state register together with the held key outputs.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= IDLE;
            key_code <= 8'h00;
            key_ext  <= 1'b0;
            key_down <= 1'b0;
        end else begin
            state    <= state_nxt;
            key_code <= code_nxt;
            key_ext  <= ext_nxt;
            key_down <= down_nxt;
        end
    end

    // Decoder next state: prefixes move into EXT/BRK, everything else returns.
    always_comb begin
        state_nxt = state;
        if (vld_p1) begin
            case (state)
                IDLE: begin
                    if (byte_p1 == CODE_E0) begin
                        state_nxt = EXT;
                    end else if (byte_p1 == CODE_F0) begin
                        state_nxt = BRK;
                    end
                end
                EXT:     state_nxt = (byte_p1 == CODE_F0) ? EXT_BRK : IDLE;
                BRK:     state_nxt = IDLE;
                EXT_BRK: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Decoder outputs: make codes load the key, matching break codes release it.
    always_comb begin
        code_nxt = key_code;
        ext_nxt  = key_ext;
        down_nxt = key_down;
        if (vld_p1) begin
            case (state)
                IDLE: begin
                    if (byte_p1 != CODE_E0 && byte_p1 != CODE_F0) begin
                        code_nxt = byte_p1;
                        ext_nxt  = 1'b0;
                        down_nxt = 1'b1;
                    end
                end
                EXT: begin
                    if (byte_p1 != CODE_F0) begin
                        code_nxt = byte_p1;
                        ext_nxt  = 1'b1;
                        down_nxt = 1'b1;
                    end
                end
                BRK: begin
                    if (byte_p1 == key_code && !key_ext) begin
                        down_nxt = 1'b0;
                    end
                end
                EXT_BRK: begin
                    if (byte_p1 == key_code && key_ext) begin
                        down_nxt = 1'b0;
                    end
                end
                default: begin
                    down_nxt = key_down;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver: PS/2 frames are bit-banged into the
// DUT, good bytes are queued in a scoreboard and compared as they are popped.
module tb_ps2_scan_receiver;

    localparam int TO_CYC = 300;
    localparam int HALF   = 8;

    logic       clk;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_down;

    int         total;
    int         bad;
    int         err_cnt;
    int         err_base;
    logic [7:0] exp_q[$];
    logic       model_ovf;

    ps2_scan_receiver #(
        .FIFO_AW       (3),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .nextdata_n(nextdata_n),
        .data      (data),
        .ready     (ready),
        .overflow  (overflow),
        .frame_err (frame_err),
        .key_code  (key_code),
        .key_ext   (key_ext),
        .key_down  (key_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame_err pulses, sampled away from the active edge.
    initial err_cnt = 0;
    always @(negedge clk) begin
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [7:0] b);
        if (exp_q.size() < 8) exp_q.push_back(b);
        else model_ovf = 1'b1;
    endtask

    task automatic sb_clear();
        exp_q.delete();
        model_ovf = 1'b0;
    endtask

    // Drive nbits of a frame LSB first; optionally pop exactly on the cycle
    // the final byte is written into the FIFO.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit pop_mid);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            for (int j = 1; j <= HALF; j++) begin
                @(negedge clk);
                if (pop_mid && i == 10 && j == 3) begin
                    if (exp_q.size() > 0) begin
                        check("simul_head", 32'(data), 32'(exp_q[0]));
                        void'(exp_q.pop_front());
                    end
                    nextdata_n = 1'b0;
                end
                if (pop_mid && i == 10 && j == 4) nextdata_n = 1'b1;
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit pop_mid);
        logic [10:0] bits;
        bits[0]    = 1'b0;
        bits[8:1]  = b;
        bits[9]    = (~^b) ^ bad_par;
        bits[10]   = ~bad_stop;
        send_bits(bits, 11, pop_mid);
        if (!bad_par && !bad_stop) sb_push(b);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 1'b0);
    endtask

    // Wait (bounded) for a byte, compare it with the scoreboard head, pop it.
    task automatic pop_check(input string tag);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(ready), 32'(1));
        if (exp_q.size() > 0) check(tag, 32'(data), 32'(exp_q.pop_front()));
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b0;
        sb_clear();
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        model_ovf  = 1'b0;
        clrn       = 1'b0;
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        nextdata_n = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ready", 32'(ready), 32'(0));
        check("rst_data", 32'(data), 32'(0));
        check("rst_ovf", 32'(overflow), 32'(0));
        check("rst_ferr", 32'(frame_err), 32'(0));
        check("rst_key", 32'({key_code, key_ext, key_down}), 32'(0));
        clrn = 1'b1;
        repeat (3) @(negedge clk);

        // Single make code
        send_byte(8'h1C);
        check("a_ready", 32'(ready), 32'(1));
        check("a_code", 32'(key_code), 32'h1C);
        check("a_ext", 32'(key_ext), 32'(0));
        check("a_down", 32'(key_down), 32'(1));
        pop_check("a_data");
        check("a_empty", 32'(ready), 32'(0));

        // Break of A, then extended make and extended break
        send_byte(8'hF0);
        send_byte(8'h1C);
        check("brk_down", 32'(key_down), 32'(0));
        check("brk_code", 32'(key_code), 32'h1C);
        send_byte(8'hE0);
        send_byte(8'h75);
        check("ext_code", 32'(key_code), 32'h75);
        check("ext_ext", 32'(key_ext), 32'(1));
        check("ext_down", 32'(key_down), 32'(1));
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        check("extbrk_down", 32'(key_down), 32'(0));
        check("extbrk_code", 32'(key_code), 32'h75);
        for (int k = 0; k < 7; k++) pop_check("seq_data");
        check("seq_empty", 32'(ready), 32'(0));

        // Bad parity and bad stop frames
        err_base = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        check("par_err", 32'(err_cnt - err_base), 32'(1));
        check("par_ready", 32'(ready), 32'(0));
        check("par_key", 32'({key_code, key_ext, key_down}), 32'({8'h75, 1'b1, 1'b0}));
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        check("stop_err", 32'(err_cnt - err_base), 32'(2));
        check("stop_ready", 32'(ready), 32'(0));
        check("stop_key", 32'({key_code, key_ext, key_down}), 32'({8'h75, 1'b1, 1'b0}));

        // Timeout of a partial frame, then a clean frame
        err_base = err_cnt;
        send_bits(11'b110_0101_0010, 5, 1'b0);
        check("to_early", 32'(err_cnt - err_base), 32'(0));
        repeat (TO_CYC + 20) @(negedge clk);
        check("to_err", 32'(err_cnt - err_base), 32'(1));
        check("to_ready", 32'(ready), 32'(0));
        send_byte(8'h29);
        check("to_noerr", 32'(err_cnt - err_base), 32'(1));
        check("to_code", 32'(key_code), 32'h29);
        pop_check("to_data");

        // Overflow: nine pushes, eight survive
        for (int k = 1; k <= 8; k++) send_byte(8'(k));
        check("ovf_not_yet", 32'(overflow), 32'(model_ovf));
        send_byte(8'h09);
        check("ovf_set", 32'(overflow), 32'(model_ovf));
        check("ovf_key", 32'(key_code), 32'h09);
        for (int k = 0; k < 8; k++) pop_check("ovf_data");
        check("ovf_empty", 32'(ready), 32'(0));
        check("ovf_sticky", 32'(overflow), 32'(1));

        // Full FIFO with simultaneous push and pop
        do_reset();
        check("rr_ovf", 32'(overflow), 32'(0));
        for (int k = 1; k <= 8; k++) send_byte(8'(8'h10 + k));
        check("full_noovf", 32'(overflow), 32'(0));
        send_frame(8'h19, 1'b0, 1'b0, 1'b1);
        check("simul_ovf", 32'(overflow), 32'(model_ovf));
        for (int k = 0; k < 8; k++) pop_check("simul_data");
        check("simul_empty", 32'(ready), 32'(0));

        // Reset mid-frame while the FIFO holds three bytes
        send_byte(8'h31);
        send_byte(8'h32);
        send_byte(8'h33);
        send_bits(11'b100_0100_1000, 7, 1'b0);
        @(negedge clk);
        clrn = 1'b0;
        sb_clear();
        #1;
        check("mr_ready", 32'(ready), 32'(0));
        check("mr_data", 32'(data), 32'(0));
        check("mr_key", 32'({key_code, key_ext, key_down}), 32'(0));
        check("mr_ovf_ferr", 32'({overflow, frame_err}), 32'(0));
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        repeat (3) @(negedge clk);
        send_byte(8'h44);
        check("mr_code", 32'(key_code), 32'h44);
        check("mr_down", 32'(key_down), 32'(1));
        pop_check("mr_data2");
        check("mr_empty", 32'(ready), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_scan_receiver.md
Name: ps2_scan_receiver

Overview:
Upstream producer for the keyed lookup mux stage. It deserialises PS/2 keyboard frames on the system clock and buffers valid scan-code bytes in a small FIFO for a byte consumer. It also tracks the make/break/extended state of the most recent key. Its key_code/key_ext outputs are the key input of the scan-code-to-ASCII/segment lookup stage directly downstream.

Parameters:
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW (default 8 entries).
TIMEOUT_CYCLES, 50000, clk cycles without a ps2_clk falling edge after which a partial frame is aborted.

Ports:
clk  input  1  system clock; all state on rising edge.
clrn  input  1  asynchronous active-low reset.
ps2_clk  input  1  raw PS/2 clock from device, asynchronous.
ps2_data  input  1  raw PS/2 data from device, asynchronous.
nextdata_n  input  1  active-low pop request; honoured only when ready=1.
data  output  8  FIFO head byte; valid while ready=1.
ready  output  1  FIFO non-empty.
overflow  output  1  sticky: a valid byte was dropped because the FIFO was full.
frame_err  output  1  one-cycle pulse on a parity, start, stop or timeout error.
key_code  output  8  last make/break code, excluding E0/F0 prefixes.
key_ext  output  1  key_code was preceded by E0.
key_down  output  1  key_code is currently held.

Behaviour:
- Reset (clrn=0, asynchronous): all outputs are 0. FIFO pointers are 0. Sync flops are 1. Bit counter is 0. Timeout counter is 0. Decoder is in IDLE. Reset mid-frame discards the partial frame.
- Sync: ps2_clk and ps2_data each pass through a 3-flop synchroniser; s[2] is the oldest stage. A falling edge is s_clk[2]=1 and s_clk[1]=0. The data bit is sampled from s_data[1] on that same cycle.
- Frame: 11 bits, LSB first: start(0), d0..d7, odd parity, stop(1). A 4-bit counter 0..10 advances on each falling edge.
  - On the 11th bit the frame is valid iff start=0, stop=1 and ^{d,parity}=1.
  - Valid frame: the byte is pushed to the FIFO and fed to the decoder in the same cycle.
  - Invalid frame: frame_err pulses; the byte is discarded.
  - The counter returns to 0 in either case.
- Timeout: while counter!=0, a counter increments every cycle and clears on each falling edge. On reaching TIMEOUT_CYCLES-1 the bit counter resets to 0 and frame_err pulses. A timeout and a final-bit edge never coincide, because the edge clears the count.
- Latency: the byte appears in FIFO/ready on the 2nd clk after the clk edge at which s_clk[1] first samples the 11th ps2_clk low.
- FIFO: depth 2**FIFO_AW. Pointers are FIFO_AW+1 bits, with wrap detection by the MSB.
  - data = mem[rd_ptr] (registered memory, combinational read).
  - ready = (wr_ptr != rd_ptr).
  - Pop: when ready=1 and nextdata_n=0 at a clk edge, rd_ptr increments. nextdata_n=0 while ready=0 has no effect.
  - Push when full without a simultaneous pop: the byte is dropped and overflow is set. overflow stays 1 until reset.
  - Push when full with a simultaneous pop: both happen and there is no overflow.
  - Push when empty with a pop request: no pop; the byte is visible next cycle.
- Decoder FSM, driven by valid frames only. States: IDLE, EXT, BRK, EXT_BRK.
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte b -> key_code=b, key_ext=0, key_down=1.
  - EXT: F0 -> EXT_BRK; other b -> key_code=b, key_ext=1, key_down=1, back to IDLE.
  - BRK and EXT_BRK: byte b -> IDLE. If b==key_code and the state's ext flag equals key_ext, then key_down=0. Otherwise the outputs are unchanged.
  - Typematic repeats of a held make code rewrite identical values.
- Decoder updates are independent of FIFO fullness: a dropped byte still updates the decoder.

Test Plan:
- Send frame 0x1C (A) with correct parity -> ready=1, data=0x1C, key_code=0x1C, key_down=1, key_ext=0. Pulse nextdata_n low 1 cycle -> ready=0.
- Send F0,1C -> FIFO holds 0xF0,0x1C in order; key_down=0, key_code=0x1C. Send E0,75 -> key_code=0x75, key_ext=1, key_down=1. Send E0,F0,75 -> key_down=0.
- Send 0x1C with bad parity; separately send a frame with stop=0 -> frame_err pulses once per frame, ready stays 0, decoder unchanged.
- Stop ps2_clk after 5 bits for TIMEOUT_CYCLES cycles -> frame_err pulses once. A following clean 0x29 is received correctly as data=0x29.
- Push 9 bytes 0x01..0x09 with no pops -> overflow=1 and the FIFO reads back 0x01..0x08. Then, with the FIFO full, push and pop on the same cycle -> no drop and the order is preserved.
- Assert clrn low mid-frame (bit 6) and while the FIFO holds 3 bytes -> all outputs are 0 immediately. After release, the next full frame is received correctly.
